// File: rtl/sdo_sup_pkg.sv
// Shared definitions for the SDO timeout supervisor.
// Contents: supervisor state encoding, limit width and reset value, default retry count.
package sdo_sup_pkg;

  localparam int unsigned LIMIT_W       = 32;
  localparam int unsigned MAX_RETRY_DEF = 3;

  // All-ones keeps the counter stage from ever reaching its limit while idle.
  localparam logic [LIMIT_W-1:0] LIMIT_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/limit_backoff_calc.sv
// Next timeout limit calculator (combinational).
// Ports:
//   limit_i      current or sampled limit
//   backoff_i    1: double the limit, saturating at all-ones
//   next_limit_c resulting limit; a zero result is replaced by 1
module limit_backoff_calc
  import sdo_sup_pkg::*;
(
  input  logic [LIMIT_W-1:0] limit_i,
  input  logic               backoff_i,
  output logic [LIMIT_W-1:0] next_limit_c
);

  logic [LIMIT_W-1:0] shifted;

  // Double with saturation, then guard against a zero limit.
  always_comb begin
    shifted = limit_i;
    if (backoff_i) begin
      shifted = limit_i[LIMIT_W-1] ? LIMIT_RST : {limit_i[LIMIT_W-2:0], 1'b0};
    end
    next_limit_c = (shifted == '0) ? LIMIT_W'(1) : shifted;
  end

endmodule

// File: rtl/sdo_timeout_supervisor.sv
// Supervises one outstanding CAN SDO request/response transaction.
// Arms the downstream timeout counter (enable_timeout/time_limit), watches its
// timeout flag, and re-requests transmission up to MAX_RETRY times before
// reporting failure.
// Optional feature: define TIMEOUT_BACKOFF_EN to double time_limit on every retry.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_req       request sent, begin supervision (ignored while busy)
//   resp_valid      matching response received
//   cancel          abandon the transaction silently
//   base_limit      timeout in clk cycles, sampled on accepted start_req
//   rst_timeout     timeout flag from the counter stage (may stay high)
//   enable_timeout  counter run-enable
//   time_limit      counter limit
//   retry_req/done_ok/fail  one-cycle status pulses
//   busy            transaction in progress
//   retry_cnt       retries issued in the current transaction
module sdo_timeout_supervisor
  import sdo_sup_pkg::*;
#(
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
  parameter int unsigned RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_req,
  input  logic               resp_valid,
  input  logic               cancel,
  input  logic [LIMIT_W-1:0] base_limit,
  input  logic               rst_timeout,
  output logic               enable_timeout,
  output logic [LIMIT_W-1:0] time_limit,
  output logic               retry_req,
  output logic               done_ok,
  output logic               fail,
  output logic               busy,
  output logic [RETRY_W-1:0] retry_cnt
);

  state_e             state_q, state_d;
  logic               rst_timeout_q;
  logic               enable_q, enable_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic               retry_req_q, retry_req_d;
  logic               done_ok_q, done_ok_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic [RETRY_W-1:0] cnt_q, cnt_d;

  logic               timeout_ev;
  logic [LIMIT_W-1:0] calc_limit;
  logic               calc_backoff;
  logic [LIMIT_W-1:0] calc_next;

  // Only a rising edge of the flag is a timeout event.
  assign timeout_ev = rst_timeout & ~rst_timeout_q;

  // In IDLE the calculator cleans up base_limit; otherwise it yields the retry limit.
  assign calc_limit = (state_q == IDLE) ? base_limit : limit_q;
`ifdef TIMEOUT_BACKOFF_EN
  assign calc_backoff = (state_q != IDLE);
`else
  assign calc_backoff = 1'b0;
`endif

  limit_backoff_calc u_calc (
    .limit_i      (calc_limit),
    .backoff_i    (calc_backoff),
    .next_limit_c (calc_next)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rst_timeout_q <= 1'b0;
      enable_q      <= 1'b0;
      limit_q       <= LIMIT_RST;
      retry_req_q   <= 1'b0;
      done_ok_q     <= 1'b0;
      fail_q        <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rst_timeout_q <= rst_timeout;
      enable_q      <= enable_d;
      limit_q       <= limit_d;
      retry_req_q   <= retry_req_d;
      done_ok_q     <= done_ok_d;
      fail_q        <= fail_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and output logic; cancel > resp_valid > timeout event.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    limit_d     = limit_q;
    retry_req_d = 1'b0;
    done_ok_d   = 1'b0;
    fail_d      = 1'b0;
    busy_d      = busy_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        enable_d = 1'b0;
        if (start_req) begin
          limit_d = calc_next;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end

      // Hold off while the previous timeout flag is still high.
      ARM: begin
        enable_d = 1'b0;
        if (cancel) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!rst_timeout) begin
          enable_d = 1'b1;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        enable_d = 1'b1;
        if (cancel) begin
          enable_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (resp_valid) begin
          done_ok_d = 1'b1;
          enable_d  = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (timeout_ev) begin
          enable_d = 1'b0;
          if (cnt_q < RETRY_W'(MAX_RETRY)) begin
            cnt_d       = cnt_q + RETRY_W'(1);
            retry_req_d = 1'b1;
            limit_d     = calc_next;
            state_d     = ARM;
          end else begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        enable_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign enable_timeout = enable_q;
  assign time_limit     = limit_q;
  assign retry_req      = retry_req_q;
  assign done_ok        = done_ok_q;
  assign fail           = fail_q;
  assign busy           = busy_q;
  assign retry_cnt      = cnt_q;

endmodule

// File: tb/tb_sdo_timeout_supervisor.sv
// Directed self-checking bench for sdo_timeout_supervisor, with a simple
// behavioural timeout counter stage that can be swapped for a manual flag.
module tb_sdo_timeout_supervisor;

  localparam int unsigned RW = 2;
`ifdef TIMEOUT_BACKOFF_EN
  localparam bit BO = 1'b1;
`else
  localparam bit BO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_req = 1'b0;
  logic          resp_valid = 1'b0;
  logic          cancel = 1'b0;
  logic          man_to = 1'b0;
  logic          use_model = 1'b0;
  logic [31:0]   base_limit = 32'd0;
  logic          rst_timeout;
  logic          model_to;
  logic          enable_timeout;
  logic [31:0]   time_limit;
  logic          retry_req, done_ok, fail, busy;
  logic [RW-1:0] retry_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int n_retry = 0, n_done = 0, n_fail = 0, n_viol = 0;
  logic to_prev = 1'b0;

  logic [31:0] mcnt;
  int unsigned mhold;

  always #5 clk = ~clk;

  sdo_timeout_supervisor #(.MAX_RETRY(3), .RETRY_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_req      (start_req),
    .resp_valid     (resp_valid),
    .cancel         (cancel),
    .base_limit     (base_limit),
    .rst_timeout    (rst_timeout),
    .enable_timeout (enable_timeout),
    .time_limit     (time_limit),
    .retry_req      (retry_req),
    .done_ok        (done_ok),
    .fail           (fail),
    .busy           (busy),
    .retry_cnt      (retry_cnt)
  );

  // Counter stage: fires on the time_limit-th enabled cycle, flag high 3 cycles.
  assign model_to    = (mhold != 0);
  assign rst_timeout = use_model ? model_to : man_to;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt  <= 32'd0;
      mhold <= 0;
    end else if (mhold != 0) begin
      mhold <= mhold - 1;
      mcnt  <= 32'd0;
    end else if (enable_timeout) begin
      if (mcnt + 32'd1 >= time_limit) begin
        mhold <= 3;
        mcnt  <= 32'd0;
      end else begin
        mcnt <= mcnt + 32'd1;
      end
    end else begin
      mcnt <= 32'd0;
    end
  end

  // Pulse counters and the enable-low-while-flag-high watch.
  always @(negedge clk) begin
    if (retry_req) n_retry++;
    if (done_ok)   n_done++;
    if (fail)      n_fail++;
    if (rst_timeout && to_prev && enable_timeout) n_viol++;
    to_prev = rst_timeout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] lim);
    base_limit = lim;
    start_req  = 1'b1;
    tick();
    start_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, d0, f0;
    logic got;
    logic [31:0] exp;

    // Reset values
    repeat (3) tick();
    chk("rst_en", enable_timeout, 0);
    chk("rst_lim", time_limit, 32'hFFFF_FFFF);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", retry_cnt, 0);
    chk("rst_pulses", {retry_req, done_ok, fail}, 0);
    rst = 1'b1;
    tick();

    // Case 1: response 5 cycles after enable rises
    use_model = 1'b1;
    r0 = n_retry;
    start(32'd10);
    chk("c1_busy", busy, 1);
    chk("c1_lim", time_limit, 32'd10);
    chk("c1_en_arm", enable_timeout, 0);
    tick();
    chk("c1_en", enable_timeout, 1);
    repeat (4) tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("c1_done", done_ok, 1);
    chk("c1_cnt", retry_cnt, 0);
    chk("c1_busy_end", busy, 0);
    chk("c1_en_end", enable_timeout, 0);
    chk("c1_noretry", n_retry - r0, 0);

    // Case 2: no response, real counter stage
    r0 = n_retry;
    f0 = n_fail;
    start(32'd8);
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (fail) begin
        got = 1'b1;
        break;
      end
    end
    chk("c2_fail_seen", got, 1);
    chk("c2_retries", n_retry - r0, 3);
    chk("c2_cnt", retry_cnt, 3);
    chk("c2_busy", busy, 0);
    tick();
    chk("c2_fail_once", n_fail - f0, 1);
    use_model = 1'b0;
    repeat (4) tick();

    // Case 3: response coincides with timeout rising edge
    r0 = n_retry;
    start(32'd100);
    tick();
    chk("c3_en", enable_timeout, 1);
    man_to = 1'b1;
    resp_valid = 1'b1;
    tick();
    man_to = 1'b0;
    resp_valid = 1'b0;
    chk("c3_done", done_ok, 1);
    chk("c3_retry", retry_req, 0);
    chk("c3_busy", busy, 0);
    tick();
    chk("c3_noretry", n_retry - r0, 0);

    // Case 4: cancel during the second WAIT
    start(32'd50);
    tick();
    man_to = 1'b1;
    tick();
    man_to = 1'b0;
    chk("c4_retry", retry_req, 1);
    chk("c4_cnt1", retry_cnt, 1);
    chk("c4_en_arm", enable_timeout, 0);
    tick();
    chk("c4_en_wait2", enable_timeout, 1);
    d0 = n_done;
    f0 = n_fail;
    r0 = n_retry;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("c4_busy", busy, 0);
    chk("c4_en", enable_timeout, 0);
    chk("c4_cnt_hold", retry_cnt, 1);
    tick();
    chk("c4_nopulse", (n_done - d0) + (n_fail - f0) + (n_retry - r0), 0);
    start(32'd50);
    chk("c4_cnt_clr", retry_cnt, 0);
    chk("c4_busy2", busy, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("c4_cancel_arm", busy, 0);

    // Case 5: zero limit, flag high across start
    man_to = 1'b1;
    start(32'd0);
    chk("c5_lim", time_limit, 32'd1);
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("c5_en_hold", enable_timeout, 0);
    chk("c5_resp_ign", done_ok, 0);
    chk("c5_busy", busy, 1);
    man_to = 1'b0;
    tick();
    chk("c5_en", enable_timeout, 1);
    start(32'd55);
    chk("c5_start_ign", time_limit, 32'd1);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("c5_done", done_ok, 1);

    // Case 6: limit across retries (doubles with backoff, else fixed)
    start(32'd4);
    tick();
    chk("c6_lim0", time_limit, 32'd4);
    for (int k = 1; k <= 3; k++) begin
      man_to = 1'b1;
      tick();
      man_to = 1'b0;
      exp = BO ? (32'd4 << k) : 32'd4;
      chk("c6_retry", retry_req, 1);
      chk("c6_lim", time_limit, exp);
      tick();
    end
    man_to = 1'b1;
    tick();
    man_to = 1'b0;
    chk("c6_fail", fail, 1);
    chk("c6_cnt", retry_cnt, 3);
    tick();

    start(32'h9000_0000);
    tick();
    man_to = 1'b1;
    tick();
    man_to = 1'b0;
    chk("c6_sat", time_limit, BO ? 32'hFFFF_FFFF : 32'h9000_0000);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;

    // Asynchronous reset mid-transaction
    start(32'd20);
    tick();
    #3;
    rst = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_en", enable_timeout, 0);
    chk("ar_lim", time_limit, 32'hFFFF_FFFF);
    #2;
    rst = 1'b1;
    tick();

    chk("en_low_while_to", n_viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
